hex_hello_decoder: RTL

Sequential decoder for the eight-digit seven-segment "HELLO" scroller bus. On a start pulse it snapshots the eight active-low glyph buses HEX0..HEX7 and decodes each glyph into a 3-bit character code, one digit per clock. It then searches the eight scroll rotations for a match and reports the rotation index. It sits on the receiving end of the display bus, for self-check and loopback of the scroller on the board.

---
 rtl/hex_hello_decoder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/hex_hello_decoder.sv
// Receiving-side decoder for the eight-digit seven-segment HELLO scroller bus.
// Snapshots HEX0..HEX7, decodes one digit per clock, then searches the eight scroll rotations.
module hex_hello_decoder (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [0:6]  HEX0,
    input  logic [0:6]  HEX1,
    input  logic [0:6]  HEX2,
    input  logic [0:6]  HEX3,
    input  logic [0:6]  HEX4,
    input  logic [0:6]  HEX5,
    input  logic [0:6]  HEX6,
    input  logic [0:6]  HEX7,
    output logic        BUSY,
    output logic        DONE,
    output logic        VALID,
    output logic [2:0]  ROT,
    output logic [23:0] CODES
);

    localparam logic [2:0] CH_SPACE = 3'd0;
    localparam logic [2:0] CH_H     = 3'd1;
    localparam logic [2:0] CH_E     = 3'd2;
    localparam logic [2:0] CH_L     = 3'd3;
    localparam logic [2:0] CH_O     = 3'd4;
    localparam logic [2:0] CH_BAD   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_MATCH,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [0:6]  hex_in [8];
    logic [0:6]  snap   [8];
    logic [2:0]  code   [8];
    logic [2:0]  idx;
    logic [2:0]  rot_r;
    logic        rot_hit;
    logic [23:0] codes_flat;

    // Active-low glyph pattern to character code; anything unrecognised is invalid.
    function automatic logic [2:0] glyph_decode(input logic [0:6] g);
        logic [2:0] c;
        case (g)
            7'b1111111: c = CH_SPACE;
            7'b0001001: c = CH_H;
            7'b0000110: c = CH_E;
            7'b1000111: c = CH_L;
            7'b1000000: c = CH_O;
            default:    c = CH_BAD;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] msg_char(input logic [2:0] pos);
        logic [2:0] c;
        case (pos)
            3'd0, 3'd1, 3'd2: c = CH_SPACE;
            3'd3:             c = CH_H;
            3'd4:             c = CH_E;
            3'd5, 3'd6:       c = CH_L;
            default:          c = CH_O;
        endcase
        return c;
    endfunction

    // Digit i shows S[(7-i+r) mod 8]; in 3-bit arithmetic 7-i is simply ~i.
    function automatic logic [2:0] rot_char(input logic [2:0] digit, input logic [2:0] r);
        logic [2:0] pos;
        pos = r + ~digit;
        return msg_char(pos);
    endfunction

    assign hex_in[0] = HEX0;
    assign hex_in[1] = HEX1;
    assign hex_in[2] = HEX2;
    assign hex_in[3] = HEX3;
    assign hex_in[4] = HEX4;
    assign hex_in[5] = HEX5;
    assign hex_in[6] = HEX6;
    assign hex_in[7] = HEX7;

    always_comb begin
        rot_hit = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (code[i] != rot_char(3'(i), rot_r)) begin
                rot_hit = 1'b0;
            end
        end
    end

    always_comb begin
        codes_flat = '0;
        for (int i = 0; i < 8; i++) begin
            codes_flat[3*i +: 3] = code[i];
        end
    end

    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                BUSY = 1'b1;
                if (idx == 3'd7) begin
                    state_nxt = S_MATCH;
                end
            end
            S_MATCH: begin
                BUSY = 1'b1;
                if (rot_hit || rot_r == 3'd7) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                DONE      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            idx   <= '0;
            rot_r <= '0;
            VALID <= 1'b0;
            ROT   <= '0;
            CODES <= '0;
            for (int i = 0; i < 8; i++) begin
                snap[i] <= '0;
                code[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                // Snapshot stage: freeze the bus so later input changes cannot disturb the result
                S_IDLE: begin
                    if (START) begin
                        for (int i = 0; i < 8; i++) begin
                            snap[i] <= hex_in[i];
                        end
                        idx <= '0;
                    end
                end
                // Decode stage: one digit per clock
                S_SCAN: begin
                    code[idx] <= glyph_decode(snap[idx]);
                    idx       <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        rot_r <= '0;
                    end
                end
                // Match stage: one rotation per clock, first hit wins
                S_MATCH: begin
                    if (rot_hit) begin
                        ROT   <= rot_r;
                        VALID <= 1'b1;
                        CODES <= codes_flat;
                    end else if (rot_r == 3'd7) begin
                        ROT   <= '0;
                        VALID <= 1'b0;
                        CODES <= codes_flat;
                    end else begin
                        rot_r <= rot_r + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
